ag_vram_arbiter: RTL and testbench

Time-multiplexes one single-port 32Kx8 synchronous RAM between the 6502 CPU and the video fetch engine, so the video RAM no longer needs a second port. Video requests get priority, and a starvation limit guarantees CPU progress. Video reads return one 16-bit word assembled from two byte reads. The block sits between `ag6502`/`ag_video` and the RAM macro, and all logic runs in the `clk50` domain.

---
 rtl/ag_vram_arbiter.sv | 123 ++++++++++++
 tb/tb_ag_vram_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ag_vram_arbiter.sv
// Shares one single-port 32Kx8 synchronous RAM between the CPU and the video fetch
// engine; video has priority, bounded by a starvation limit that protects the CPU.
module ag_vram_arbiter #(
   parameter int STARVE_MAX = 2
) (
   input  logic        clk50,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_read,
   input  logic [14:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_ack,
   input  logic        vid_req,
   input  logic [13:0] vid_addr,
   output logic [15:0] vid_data,
   output logic        vid_ack,
   output logic [14:0] ram_addr,
   output logic        ram_we,
   output logic [7:0]  ram_wdata,
   input  logic [7:0]  ram_rdata
);

   typedef enum logic [2:0] {
      IDLE,
      V_LO,
      V_HI,
      V_CAP,
      C_RD,
      C_CAP,
      C_WR
   } state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t      state;
   logic [3:0]  starve_cnt;
   logic [13:0] vid_addr_q;
   logic [7:0]  lo_byte;

   logic vid_elig;
   logic cpu_elig;
   logic grant_vid;
   logic grant_cpu;

   // A requester is ignored during its own ack cycle so it has time to drop req.
   assign vid_elig  = vid_req && !vid_ack;
   assign cpu_elig  = cpu_req && !cpu_ack;
   assign grant_vid = vid_elig && (!cpu_elig || (starve_cnt != STARVE_LIM));
   assign grant_cpu = cpu_elig && !grant_vid;

   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         starve_cnt <= 4'd0;
         vid_addr_q <= 14'd0;
         lo_byte    <= 8'd0;
         ram_addr   <= 15'd0;
         ram_we     <= 1'b0;
         ram_wdata  <= 8'd0;
         cpu_rdata  <= 8'd0;
         cpu_ack    <= 1'b0;
         vid_data   <= 16'd0;
         vid_ack    <= 1'b0;
      end else begin
         cpu_ack <= 1'b0;
         vid_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_vid) begin
                  vid_addr_q <= vid_addr;
                  ram_addr   <= {vid_addr, 1'b0};
                  state      <= V_LO;
                  if (!cpu_req) begin
                     starve_cnt <= 4'd0;
                  end else if (starve_cnt < STARVE_LIM) begin
                     starve_cnt <= starve_cnt + 4'd1;
                  end
               end else if (grant_cpu) begin
                  starve_cnt <= 4'd0;
                  ram_addr   <= cpu_addr;
                  ram_wdata  <= cpu_wdata;
                  ram_we     <= !cpu_read;
                  state      <= cpu_read ? C_RD : C_WR;
               end else if (!cpu_req) begin
                  starve_cnt <= 4'd0;
               end
            end
            V_LO: begin
               ram_addr <= {vid_addr_q, 1'b1};
               state    <= V_HI;
            end
            // Low byte read data is valid in this cycle; high byte follows one cycle later.
            V_HI: begin
               lo_byte <= ram_rdata;
               state   <= V_CAP;
            end
            V_CAP: begin
               vid_data <= {ram_rdata, lo_byte};
               vid_ack  <= 1'b1;
               state    <= IDLE;
            end
            C_RD: begin
               state <= C_CAP;
            end
            C_CAP: begin
               cpu_rdata <= ram_rdata;
               cpu_ack   <= 1'b1;
               state     <= IDLE;
            end
            C_WR: begin
               ram_we  <= 1'b0;
               cpu_ack <= 1'b1;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ag_vram_arbiter.sv
// Randomized and directed bench for ag_vram_arbiter, checked against a transaction-level
// reference model (per-requester eligibility, edge countdowns and a flat byte memory).
module tb_ag_vram_arbiter;

   localparam int SM = 2;
   localparam int CPU_WAIT_MAX = SM * 4 + 1 + 3;
   localparam int TIMEOUT = 200;

   logic        clk50;
   logic        reset;
   logic        cpu_req;
   logic        cpu_read;
   logic [14:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_ack;
   logic        vid_req;
   logic [13:0] vid_addr;
   logic [15:0] vid_data;
   logic        vid_ack;
   logic [14:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;

   int errorCount = 0;
   int checkCount = 0;
   bit checkEn = 0;

   ag_vram_arbiter #(.STARVE_MAX(SM)) dut (
      .clk50    (clk50),
      .reset    (reset),
      .cpu_req  (cpu_req),
      .cpu_read (cpu_read),
      .cpu_addr (cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata),
      .cpu_ack  (cpu_ack),
      .vid_req  (vid_req),
      .vid_addr (vid_addr),
      .vid_data (vid_data),
      .vid_ack  (vid_ack),
      .ram_addr (ram_addr),
      .ram_we   (ram_we),
      .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   initial begin
      clk50 = 0;
      forever #5 clk50 = ~clk50;
   end

   // Synchronous RAM seen by the DUT.
   logic [7:0] ramArr [0:32767];
   always @(posedge clk50) begin
      if (ram_we) ramArr[ram_addr] <= ram_wdata;
      ram_rdata <= ramArr[ram_addr];
   end

   // Reference model: which requester wins in idle, how many edges until it completes,
   // and what the memory holds once it does.
   logic [7:0]  refMem [0:32767];
   int          mRem, mKind, mCnt;
   logic [14:0] mCaddr;
   logic [13:0] mVaddr;
   logic [7:0]  mCwd, mCdata;
   logic [15:0] mVdata;
   bit          mVack, mCack, mWe, mLastRd, nV, nC, ve, ce;

   always @(posedge clk50 or posedge reset) begin
      if (reset) begin
         mRem = 0; mKind = 0; mCnt = 0;
         mVack = 0; mCack = 0; mWe = 0; mLastRd = 0;
         mVdata = 0; mCdata = 0;
      end else begin
         nV = 0; nC = 0;
         if (mRem > 0) begin
            mRem = mRem - 1;
            if (mRem == 0) begin
               if (mKind == 1) begin
                  mVdata = {refMem[{mVaddr, 1'b1}], refMem[{mVaddr, 1'b0}]};
                  nV = 1;
               end else if (mKind == 2) begin
                  mCdata = refMem[mCaddr];
                  mLastRd = 1;
                  nC = 1;
               end else begin
                  refMem[mCaddr] = mCwd;
                  mLastRd = 0;
                  nC = 1;
               end
            end
         end else begin
            ve = vid_req && !mVack;
            ce = cpu_req && !mCack;
            if (ve && (!ce || mCnt != SM)) begin
               mKind = 1; mRem = 3; mVaddr = vid_addr;
               if (cpu_req) mCnt = (mCnt < SM) ? mCnt + 1 : mCnt;
               else mCnt = 0;
            end else if (ce) begin
               mKind = cpu_read ? 2 : 3;
               mRem = cpu_read ? 2 : 1;
               mCaddr = cpu_addr; mCwd = cpu_wdata; mCnt = 0;
            end else if (!cpu_req) begin
               mCnt = 0;
            end
         end
         mVack = nV;
         mCack = nC;
         mWe = (mRem == 1) && (mKind == 3);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk50) begin
      if (checkEn) begin
         checkOutput("vidAck", 32'(vid_ack), 32'(mVack));
         checkOutput("cpuAck", 32'(cpu_ack), 32'(mCack));
         checkOutput("ramWe", 32'(ram_we), 32'(mWe));
         if (mVack) checkOutput("vidData", 32'(vid_data), 32'(mVdata));
         if (mCack && mLastRd) checkOutput("cpuRdata", 32'(cpu_rdata), 32'(mCdata));
         if (mWe) begin
            checkOutput("ramAddr", 32'(ram_addr), 32'(mCaddr));
            checkOutput("ramWdata", 32'(ram_wdata), 32'(mCwd));
         end
      end
   end

   task automatic cpuAccess(input bit rd, input logic [14:0] addr, input logic [7:0] wd,
                            input bit holdExtra, input bit scramble,
                            output int lat, output logic [7:0] rdv);
      @(negedge clk50);
      cpu_req = 1; cpu_read = rd; cpu_addr = addr; cpu_wdata = wd;
      lat = 0;
      rdv = 0;
      while (1) begin
         @(negedge clk50);
         lat++;
         if (cpu_ack) break;
         if (lat >= TIMEOUT) begin
            checkOutput("cpuTimeout", 32'd1, 32'd0);
            break;
         end
         if (scramble) begin
            cpu_addr = 15'($urandom_range(0, 63));
            cpu_wdata = 8'($urandom);
         end
      end
      rdv = cpu_rdata;
      if (holdExtra) @(negedge clk50);
      cpu_req = 0;
   endtask

   task automatic vidAccess(input logic [13:0] addr, input bit holdExtra,
                            output int lat, output logic [15:0] data);
      @(negedge clk50);
      vid_req = 1; vid_addr = addr;
      lat = 0;
      while (1) begin
         @(negedge clk50);
         lat++;
         if (vid_ack) break;
         if (lat >= TIMEOUT) begin
            checkOutput("vidTimeout", 32'd1, 32'd0);
            break;
         end
      end
      data = vid_data;
      if (holdExtra) @(negedge clk50);
      vid_req = 0;
   endtask

   task automatic applyStimulus(input int n);
      fork
         begin
            int lat;
            logic [7:0] rdv;
            for (int i = 0; i < n; i++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk50);
               cpuAccess(1'($urandom), 15'($urandom_range(0, 63)), 8'($urandom),
                         1'($urandom), 1, lat, rdv);
               checkOutput("cpuWaitBound", 32'(lat <= CPU_WAIT_MAX), 32'd1);
            end
         end
         begin
            int lat;
            logic [15:0] d;
            for (int i = 0; i < n; i++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk50);
               vidAccess(14'($urandom_range(0, 31)), 1'($urandom), lat, d);
            end
         end
      join
   endtask

   initial begin
      int lat, lastC, maxGap, nCpu, vOrd, cOrd;
      logic [7:0] rdv;
      logic [15:0] vd, vSeenData;
      logic [7:0] cSeenData;

      for (int i = 0; i < 32768; i++) begin
         ramArr[i] = 8'($urandom);
         refMem[i] = ramArr[i];
      end
      ramArr[15'h0A00] = 8'h11; refMem[15'h0A00] = 8'h11;
      ramArr[15'h0A01] = 8'h22; refMem[15'h0A01] = 8'h22;

      reset = 0; cpu_req = 0; cpu_read = 0; cpu_addr = 0; cpu_wdata = 0;
      vid_req = 0; vid_addr = 0;
      #1 reset = 1;
      repeat (2) @(negedge clk50);
      checkOutput("rstRamAddr", 32'(ram_addr), 32'd0);
      checkOutput("rstRamWe", 32'(ram_we), 32'd0);
      checkOutput("rstRamWdata", 32'(ram_wdata), 32'd0);
      checkOutput("rstCpuRdata", 32'(cpu_rdata), 32'd0);
      checkOutput("rstCpuAck", 32'(cpu_ack), 32'd0);
      checkOutput("rstVidData", 32'(vid_data), 32'd0);
      checkOutput("rstVidAck", 32'(vid_ack), 32'd0);
      reset = 0;
      checkEn = 1;

      $display("[TB] CPU write then read");
      cpuAccess(0, 15'h1234, 8'h5A, 1, 0, lat, rdv);
      checkOutput("wrLatency", 32'(lat), 32'd2);
      cpuAccess(1, 15'h1234, 8'h00, 1, 0, lat, rdv);
      checkOutput("rdLatency", 32'(lat), 32'd3);
      checkOutput("rdData", 32'(rdv), 32'h5A);

      $display("[TB] Video word");
      vidAccess(14'h0500, 1, lat, vd);
      checkOutput("vidLatency", 32'(lat), 32'd4);
      checkOutput("vidWord", 32'(vd), 32'h2211);

      $display("[TB] Simultaneous request, CPU address moves while waiting");
      repeat (3) @(negedge clk50);
      vid_req = 1; vid_addr = 14'h0500;
      cpu_req = 1; cpu_read = 1; cpu_addr = 15'h0A00;
      vOrd = -1; cOrd = -1; vSeenData = 0; cSeenData = 0;
      for (int i = 0; i < 40 && cOrd < 0; i++) begin
         @(negedge clk50);
         if (i == 1) cpu_addr = 15'h0A01;
         if (vid_ack && vOrd < 0) begin vOrd = i; vSeenData = vid_data; vid_req = 0; end
         if (cpu_ack) begin cOrd = i; cSeenData = cpu_rdata; cpu_req = 0; end
      end
      vid_req = 0; cpu_req = 0;
      checkOutput("simVidFirst", 32'((vOrd >= 0) && (cOrd > vOrd)), 32'd1);
      checkOutput("simVidData", 32'(vSeenData), 32'h2211);
      checkOutput("simCpuData", 32'(cSeenData), 32'h22);

      $display("[TB] Reset during V_HI");
      repeat (3) @(negedge clk50);
      vid_req = 1; vid_addr = 14'h0500;
      @(posedge clk50);
      @(posedge clk50);
      #2 reset = 1;
      #1;
      checkOutput("midRstRamAddr", 32'(ram_addr), 32'd0);
      checkOutput("midRstRamWe", 32'(ram_we), 32'd0);
      checkOutput("midRstVidAck", 32'(vid_ack), 32'd0);
      checkOutput("midRstVidData", 32'(vid_data), 32'd0);
      checkOutput("midRstCpuRdata", 32'(cpu_rdata), 32'd0);
      @(negedge clk50);
      @(negedge clk50);
      reset = 0;
      lat = 0;
      while (!vid_ack && lat < TIMEOUT) begin
         @(negedge clk50);
         lat++;
      end
      checkOutput("postRstVidAckSeen", 32'(vid_ack), 32'd1);
      checkOutput("postRstVidData", 32'(vid_data), 32'h2211);
      vid_req = 0;

      $display("[TB] Continuous video and CPU traffic");
      repeat (3) @(negedge clk50);
      cpu_read = 1; cpu_addr = 15'($urandom_range(0, 63));
      vid_addr = 14'($urandom_range(0, 31));
      vid_req = 1; cpu_req = 1;
      lastC = 0; maxGap = 0; nCpu = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk50);
         if (cpu_ack) begin
            if (i - lastC > maxGap) maxGap = i - lastC;
            lastC = i;
            nCpu++;
            cpu_addr = 15'($urandom_range(0, 63));
         end
         if (vid_ack) vid_addr = 14'($urandom_range(0, 31));
      end
      vid_req = 0; cpu_req = 0;
      checkOutput("starveCpuProgress", 32'(nCpu >= 4), 32'd1);
      checkOutput("starveCpuGap", 32'(maxGap <= CPU_WAIT_MAX), 32'd1);
      repeat (8) @(negedge clk50);

      $display("[TB] Randomized traffic");
      applyStimulus(60);
      repeat (8) @(negedge clk50);

      $display("[TB] Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
